// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised pipeline stage register with a valid/ready
//            handshake. It has an optional two-entry skid buffer, a
//            synchronous flush to a bubble, debug-step gating and a
//            saturating stall counter.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_reset      asynchronous active-high reset
//   i_Flush      synchronous kill of every held entry
//   i_Step       global advance enable; 0 freezes the stage
//   i_Valid      upstream entry valid
//   o_Ready      stage can accept an entry
//   i_Data       upstream payload            [NBITS]
//   i_Ctrl       upstream control bundle     [CBITS]
//   o_Valid      stage presents a valid entry
//   i_Ready      downstream accepts
//   o_Data       presented payload, 0 when empty
//   o_Ctrl       presented control, CTRL_BUBBLE when empty
//   o_Occupancy  entries held (0, 1, 2)
//   i_ClrCnt     synchronous clear of the stall counter
//   o_StallCnt   saturating count of stalled cycles [CNTBITS]
// ============================================================================
module pipe_stage_reg #(
    parameter int               NBITS       = 160,
    parameter int               CBITS       = 20,
    parameter int               SKID        = 1,
    parameter logic [CBITS-1:0] CTRL_BUBBLE = {CBITS{1'b0}},
    parameter int               CNTBITS     = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Flush,
    input  logic               i_Step,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [NBITS-1:0]   i_Data,
    input  logic [CBITS-1:0]   i_Ctrl,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic [NBITS-1:0]   o_Data,
    output logic [CBITS-1:0]   o_Ctrl,
    output logic [1:0]         o_Occupancy,
    input  logic               i_ClrCnt,
    output logic [CNTBITS-1:0] o_StallCnt
);

    // The state encoding equals the number of entries held, so it doubles
    // as the occupancy output.
    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_FULL    = 2'd1;
    localparam logic [1:0] c_ST_SKIDDED = 2'd2;

    logic [1:0]         r_state;
    logic [NBITS-1:0]   r_main_data;
    logic [CBITS-1:0]   r_main_ctrl;
    logic [CNTBITS-1:0] r_stall_cnt;
    logic               w_ready;
    logic               w_accept;
    logic               w_issue;

    assign o_Valid     = (r_state != c_ST_EMPTY);
    assign o_Ready     = w_ready;
    assign o_Data      = r_main_data;   // cleared whenever the stage empties
    assign o_Ctrl      = r_main_ctrl;   // bubble whenever the stage empties
    assign o_Occupancy = r_state;
    assign o_StallCnt  = r_stall_cnt;

    assign w_accept = i_Valid & w_ready & i_Step;
    assign w_issue  = o_Valid & i_Ready & i_Step;

    generate
        if (SKID != 0) begin : g_skid
            logic [NBITS-1:0] r_skid_data;
            logic [CBITS-1:0] r_skid_ctrl;
            logic             r_ready;

            // Ready comes straight from a flop, so there is no
            // combinational path from i_Ready back upstream.
            assign w_ready = r_ready;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_state     <= c_ST_EMPTY;
                    r_main_data <= '0;
                    r_main_ctrl <= CTRL_BUBBLE;
                    r_skid_data <= '0;
                    r_skid_ctrl <= CTRL_BUBBLE;
                    r_ready     <= 1'b1;
                end else if (i_Flush) begin
                    r_state     <= c_ST_EMPTY;
                    r_main_data <= '0;
                    r_main_ctrl <= CTRL_BUBBLE;
                    r_skid_data <= '0;
                    r_skid_ctrl <= CTRL_BUBBLE;
                    r_ready     <= 1'b1;
                end else begin
                    case (r_state)
                        c_ST_EMPTY: begin
                            if (w_accept) begin
                                r_state     <= c_ST_FULL;
                                r_main_data <= i_Data;
                                r_main_ctrl <= i_Ctrl;
                            end
                        end
                        c_ST_FULL: begin
                            if (w_accept && w_issue) begin
                                r_main_data <= i_Data;
                                r_main_ctrl <= i_Ctrl;
                            end else if (w_accept) begin
                                // Downstream stalled: park the new entry
                                // behind main and close the input.
                                r_state     <= c_ST_SKIDDED;
                                r_skid_data <= i_Data;
                                r_skid_ctrl <= i_Ctrl;
                                r_ready     <= 1'b0;
                            end else if (w_issue) begin
                                r_state     <= c_ST_EMPTY;
                                r_main_data <= '0;
                                r_main_ctrl <= CTRL_BUBBLE;
                            end
                        end
                        c_ST_SKIDDED: begin
                            // Input is closed here; only an issue moves state.
                            if (w_issue) begin
                                r_state     <= c_ST_FULL;
                                r_main_data <= r_skid_data;
                                r_main_ctrl <= r_skid_ctrl;
                                r_skid_data <= '0;
                                r_skid_ctrl <= CTRL_BUBBLE;
                                r_ready     <= 1'b1;
                            end
                        end
                        default: begin
                            r_state     <= c_ST_EMPTY;
                            r_main_data <= '0;
                            r_main_ctrl <= CTRL_BUBBLE;
                            r_skid_data <= '0;
                            r_skid_ctrl <= CTRL_BUBBLE;
                            r_ready     <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_noskid
            // A single register can take a new entry in the same cycle the
            // held one leaves, hence the combinational dependence on i_Ready.
            assign w_ready = ~o_Valid | i_Ready;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_state     <= c_ST_EMPTY;
                    r_main_data <= '0;
                    r_main_ctrl <= CTRL_BUBBLE;
                end else if (i_Flush) begin
                    r_state     <= c_ST_EMPTY;
                    r_main_data <= '0;
                    r_main_ctrl <= CTRL_BUBBLE;
                end else if (w_accept) begin
                    r_state     <= c_ST_FULL;
                    r_main_data <= i_Data;
                    r_main_ctrl <= i_Ctrl;
                end else if (w_issue) begin
                    r_state     <= c_ST_EMPTY;
                    r_main_data <= '0;
                    r_main_ctrl <= CTRL_BUBBLE;
                end
            end
        end
    endgenerate

    // Stall counter: counts cycles where an entry is held back by the
    // downstream stage while the pipeline is advancing. Flush leaves it alone.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (i_ClrCnt) begin
            r_stall_cnt <= '0;
        end else if (i_Step && o_Valid && !i_Ready &&
                     (r_stall_cnt != {CNTBITS{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Drives one skid-buffer
//            instance (4-bit counter) and one single-register instance from
//            the same stimulus, compares both against a queue-style model
//            every cycle and pins the model with hand-computed values.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam logic [7:0] c_BUB = 8'h5A;

    logic        clk;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        step = 1'b1;
    logic        vin = 1'b0;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] din = '0;
    logic [7:0]  cin = '0;

    logic        s_ready, s_valid;
    logic [15:0] s_data;
    logic [7:0]  s_ctrl;
    logic [1:0]  s_occ;
    logic [3:0]  s_cnt;

    logic        n_ready, n_valid;
    logic [15:0] n_data;
    logic [7:0]  n_ctrl;
    logic [1:0]  n_occ;
    logic [5:0]  n_cnt;

    int n_err = 0;
    int n_checks = 0;

    pipe_stage_reg #(
        .NBITS(16), .CBITS(8), .SKID(1), .CTRL_BUBBLE(c_BUB), .CNTBITS(4)
    ) u_skid (
        .i_clk(clk), .i_reset(rst), .i_Flush(flush), .i_Step(step),
        .i_Valid(vin), .o_Ready(s_ready), .i_Data(din), .i_Ctrl(cin),
        .o_Valid(s_valid), .i_Ready(rdy), .o_Data(s_data), .o_Ctrl(s_ctrl),
        .o_Occupancy(s_occ), .i_ClrCnt(clr), .o_StallCnt(s_cnt)
    );

    pipe_stage_reg #(
        .NBITS(16), .CBITS(8), .SKID(0), .CTRL_BUBBLE(c_BUB), .CNTBITS(6)
    ) u_noskid (
        .i_clk(clk), .i_reset(rst), .i_Flush(flush), .i_Step(step),
        .i_Valid(vin), .o_Ready(n_ready), .i_Data(din), .i_Ctrl(cin),
        .o_Valid(n_valid), .i_Ready(rdy), .o_Data(n_data), .o_Ctrl(n_ctrl),
        .o_Occupancy(n_occ), .i_ClrCnt(clr), .o_StallCnt(n_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model: a bounded FIFO per instance ----------
    // Instance 0 holds up to 2 entries, instance 1 up to 1.
    int          m_n[2] = '{0, 0};
    int          m_s[2] = '{0, 0};
    logic [23:0] m_e[2][2];

    function automatic bit exp_ready(input int k);
        if (k == 0) return (m_n[0] < 2);
        return (m_n[1] == 0) || rdy;
    endfunction

    task automatic model_step(input int k);
        bit valid, inx, outx;
        int smax;
        smax  = (k == 0) ? 15 : 63;
        valid = (m_n[k] > 0);
        outx  = valid && rdy && step;
        inx   = vin && exp_ready(k) && step;
        if (flush) begin
            m_n[k] = 0;
        end else begin
            if (outx) begin
                m_e[k][0] = m_e[k][1];
                m_n[k]    = m_n[k] - 1;
            end
            if (inx) begin
                m_e[k][m_n[k]] = {cin, din};
                m_n[k]         = m_n[k] + 1;
            end
        end
        if (clr) m_s[k] = 0;
        else if (step && valid && !rdy && m_s[k] < smax) m_s[k] = m_s[k] + 1;
    endtask

    always @(posedge rst) begin
        m_n = '{0, 0};
        m_s = '{0, 0};
    end

    always @(posedge clk) begin
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- checking ------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic v, input logic r, input logic [15:0] d,
                       input logic [7:0] c, input logic [1:0] o, input logic [31:0] cnt);
        bit ev;
        ev = (m_n[k] > 0);
        check($sformatf("valid%0d", k), {31'd0, v}, {31'd0, ev});
        check($sformatf("ready%0d", k), {31'd0, r}, {31'd0, exp_ready(k)});
        check($sformatf("data%0d", k), {16'd0, d}, ev ? {16'd0, m_e[k][0][15:0]} : 32'd0);
        check($sformatf("ctrl%0d", k), {24'd0, c}, ev ? {24'd0, m_e[k][0][23:16]} : {24'd0, c_BUB});
        check($sformatf("occ%0d", k), {30'd0, o}, m_n[k]);
        check($sformatf("cnt%0d", k), cnt, m_s[k]);
    endtask

    always @(negedge clk) begin
        cmp(0, s_valid, s_ready, s_data, s_ctrl, s_occ, {28'd0, s_cnt});
        cmp(1, n_valid, n_ready, n_data, n_ctrl, n_occ, {26'd0, n_cnt});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus -------------------------------------------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b1;

        // Streaming 1..8 back-to-back, one-cycle latency.
        for (int i = 1; i <= 8; i++) begin
            vin = 1'b1; din = 16'(i); cin = 8'(i);
            tick();
            check("stream_data", {16'd0, s_data}, i);
            check("stream_occ", {30'd0, s_occ}, 1);
        end
        vin = 1'b0;
        tick();
        check("stream_drain_occ", {30'd0, s_occ}, 0);

        // Backpressure with two entries.
        clr = 1'b1; tick(); clr = 1'b0;
        rdy = 1'b0; vin = 1'b1; din = 16'hA; cin = 8'h0A; tick();
        din = 16'hB; cin = 8'h0B; tick();
        vin = 1'b0; tick();
        check("bp_occ", {30'd0, s_occ}, 2);
        check("bp_ready", {31'd0, s_ready}, 0);
        check("bp_data", {16'd0, s_data}, 32'hA);
        check("bp_cnt", {28'd0, s_cnt}, 2);
        tick();
        check("bp_cnt_inc", {28'd0, s_cnt}, 3);
        rdy = 1'b1; tick();
        check("bp_rel_data", {16'd0, s_data}, 32'hB);
        check("bp_rel_ready", {31'd0, s_ready}, 1);
        tick();
        check("bp_empty", {30'd0, s_occ}, 0);

        // Flush with a same-cycle accept.
        clr = 1'b1; rdy = 1'b0; vin = 1'b1; din = 16'hA; cin = 8'h0A; tick();
        clr = 1'b0; din = 16'hB; cin = 8'h0B; tick();
        check("fl_pre_occ", {30'd0, s_occ}, 2);
        flush = 1'b1; din = 16'hC; cin = 8'h0C; rdy = 1'b1; tick();
        flush = 1'b0; vin = 1'b0;
        check("fl_valid", {31'd0, s_valid}, 0);
        check("fl_data", {16'd0, s_data}, 0);
        check("fl_ctrl", {24'd0, s_ctrl}, {24'd0, c_BUB});
        check("fl_occ", {30'd0, s_occ}, 0);
        check("fl_cnt", {28'd0, s_cnt}, 1);
        tick();
        check("fl_no_c", {31'd0, s_valid}, 0);

        // Step gating.
        vin = 1'b1; din = 16'h11; cin = 8'h11; tick();
        step = 1'b0; din = 16'h22; cin = 8'h22;
        repeat (5) begin
            tick();
            check("step_occ", {30'd0, s_occ}, 1);
            check("step_data", {16'd0, s_data}, 32'h11);
        end
        rdy = 1'b0;
        repeat (3) begin
            tick();
            check("step_cnt", {28'd0, s_cnt}, 1);
        end
        rdy = 1'b1; step = 1'b1; tick();
        check("step_resume", {16'd0, s_data}, 32'h22);
        vin = 1'b0; tick();
        check("step_drain", {30'd0, s_occ}, 0);

        // Counter saturation and clear during a stall.
        clr = 1'b1; tick(); clr = 1'b0;
        rdy = 1'b0; vin = 1'b1; din = 16'h33; cin = 8'h33; tick();
        vin = 1'b0;
        repeat (20) tick();
        check("sat_cnt", {28'd0, s_cnt}, 15);
        check("sat_data", {16'd0, s_data}, 32'h33);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_cnt", {28'd0, s_cnt}, 0);
        rdy = 1'b1; tick();

        // Asynchronous reset between edges.
        rdy = 1'b0; vin = 1'b1; din = 16'h44; cin = 8'h44; tick();
        din = 16'h55; cin = 8'h55; tick();
        vin = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, s_valid}, 0);
        check("ar_data", {16'd0, s_data}, 0);
        check("ar_ctrl", {24'd0, s_ctrl}, {24'd0, c_BUB});
        check("ar_occ", {30'd0, s_occ}, 0);
        check("ar_ready", {31'd0, s_ready}, 1);
        check("ar_cnt", {28'd0, s_cnt}, 0);
        check("ar_valid_ns", {31'd0, n_valid}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vin = 1'b1; din = 16'h66; cin = 8'h66; rdy = 1'b1; tick();
        check("ar_first", {16'd0, s_data}, 32'h66);
        check("ar_first_v", {31'd0, s_valid}, 1);
        vin = 1'b0; tick();

        // Randomised traffic, checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            vin   = ($urandom_range(0, 3) != 0);
            rdy   = (c & 256) != 0 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step  = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 31) == 0);
            clr   = ($urandom_range(0, 63) == 0);
            din   = 16'($urandom);
            cin   = 8'($urandom);
            tick();
        end
        vin = 1'b0; flush = 1'b0; clr = 1'b0; step = 1'b1; rdy = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the successor to the fixed ID/EX-style latch, used between any two stages of the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a datapath payload and a control-signal bundle with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush to a configurable bubble, global debug-step gating and a saturating stall counter for the debug unit.

## Interface
- NBITS, 160: datapath payload width (PC, operands, immediates, register indices, packed).
- CBITS, 20: control bundle width (EX/M/WB control bits, packed).
- SKID, 1: 1 = two-entry skid buffer; 0 = single register.
- CTRL_BUBBLE, {CBITS{1'b0}}: control value presented whenever the stage holds no valid entry.
- CNTBITS, 16: stall counter width.

- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_Flush  in  1  synchronous kill of all held entries.
- i_Step  in  1  global advance enable from the debug unit; 0 freezes the stage.
- i_Valid  in  1  upstream entry valid.
- o_Ready  out  1  stage can accept an entry.
- i_Data  in  NBITS  upstream payload.
- i_Ctrl  in  CBITS  upstream control bundle.
- o_Valid  out  1  stage presents a valid entry.
- i_Ready  in  1  downstream accepts.
- o_Data  out  NBITS  presented payload; 0 when o_Valid=0.
- o_Ctrl  out  CBITS  presented control; CTRL_BUBBLE when o_Valid=0.
- o_Occupancy  out  2  entries held (0, 1, 2).
- i_ClrCnt  in  1  synchronous clear of stall counter.
- o_StallCnt  out  CNTBITS  saturating count of stalled cycles.

## Operation
- Accept (in) = i_Valid & o_Ready & i_Step; Issue (out) = o_Valid & i_Ready & i_Step. Both require i_Step=1.
- States (SKID=1): EMPTY (occ 0), FULL (main valid, occ 1), SKIDDED (main+skid valid, occ 2).
  - EMPTY: in -> FULL, main<=input.
  - FULL: in&out -> FULL, main<=input; in&!out -> SKIDDED, skid<=input; !in&out -> EMPTY; else hold.
  - SKIDDED: out -> FULL, main<=skid; else hold. No accept possible.
- o_Ready (SKID=1) = (state != SKIDDED), registered; independent of i_Ready.
- SKID=0: states EMPTY/FULL only; o_Ready = ~o_Valid | i_Ready (combinational); in&out reloads main.
- On leaving an entry (EMPTY reached), main payload <= 0, main ctrl <= CTRL_BUBBLE.
- i_Flush=1: next state EMPTY, skid and main cleared to 0/CTRL_BUBBLE, any same-cycle accept discarded. Flush overrides i_Step=0 and all handshakes. Flush does not touch the stall counter.
- i_Step=0 (no flush): all state held, no accept, no issue; counter not incremented.
- Stall counter: +1 each cycle with i_Step & o_Valid & ~i_Ready; saturates at all ones; i_ClrCnt clears (priority over increment).
- Reset: state EMPTY, o_Valid=0, o_Data=0, o_Ctrl=CTRL_BUBBLE, o_Occupancy=0, o_Ready=1, o_StallCnt=0; asserting mid-transfer drops all entries immediately (asynchronously).

## Timing
- Latency: accepted entry appears on o_Data/o_Ctrl with o_Valid=1 on the cycle after acceptance.
- Throughput: one entry/cycle sustained when i_Ready=1.
- SKID=1: o_Ready falls one cycle after the skid fills; rises one cycle after SKIDDED issues. No combinational path i_Ready -> o_Ready.
- Ordering strictly FIFO; skid entry never bypasses main.
- Flush takes effect on the edge where sampled; o_Valid=0 the following cycle.
- Reset release: first accept possible on first rising edge with i_reset=0.

## Test plan
- Streaming: SKID=1, i_Step=1, i_Ready=1, push D=1..8 back-to-back -> o_Data 1..8 on consecutive cycles, one-cycle latency, o_Occupancy=1 throughout.
- Backpressure: push 0xA, 0xB with i_Ready=0 -> occ 2, o_Ready=0, o_Data=0xA, o_StallCnt increments per cycle; release i_Ready -> 0xA then 0xB issued, o_Ready=1 one cycle after 0xA leaves.
- Flush: occ 2, i_Flush=1 with i_Valid=1, D=0xC -> next cycle o_Valid=0, o_Ctrl=CTRL_BUBBLE, o_Data=0, occ 0, 0xC never appears; counter unchanged.
- Step gating: occ 1, i_Step=0 for 5 cycles with i_Ready=1, i_Valid=1 -> no issue, no accept, counter constant; i_Step=1 -> transfers resume.
- Counter saturation: CNTBITS=4, stall 20 cycles -> o_StallCnt=15 held; i_ClrCnt with stall -> 0.
- Async reset mid-stream and SKID=0 variant: i_reset between edges -> outputs at reset values immediately; SKID=0 with i_Ready toggling 1/0 -> o_Ready = ~o_Valid | i_Ready, no loss/duplication.
